// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response and data-memory signals of mem_access_ctrl
interface mem_access_ctrl_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_adr;
  logic [31:0]       mem_din;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_dout;
  modport master (
    output req, we, size, uns, addr, wdata, mem_dout,
    input  busy, done, err, rdata, mem_adr, mem_din, mem_rd, mem_wr
  );
  modport slave (
    input  req, we, size, uns, addr, wdata, mem_dout,
    output busy, done, err, rdata, mem_adr, mem_din, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator for a 32-bit byte-addressed data memory; sub-word stores via read-modify-write.
// Optional macro ALIGN_CHECK_EN rejects misaligned half/word accesses with err.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic            clk,
  input logic            rst,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, buf_q, buf_d, rdata_q, rdata_d, fmt, merge;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d, we_q, we_d, err_q, err_d, accept, bad;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  always_comb begin
`ifdef ALIGN_CHECK_EN
    bad = (bus.size == 2'b11) || (bus.size == 2'b01 && bus.addr[0]) ||
          (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
`else
    bad = (bus.size == 2'b11);
`endif
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !bus.req ? IDLE : bad ? DONE : (bus.we && bus.size == 2'b10) ? WR : RD;
      RD:      state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // Request fields are latched once at accept so the memory side never sees live CPU inputs.
  always_comb begin
    accept  = (state_q == IDLE) && bus.req;
    addr_d  = accept ? bus.addr  : addr_q;
    wdata_d = accept ? bus.wdata : wdata_q;
    size_d  = accept ? bus.size  : size_q;
    uns_d   = accept ? bus.uns   : uns_q;
    we_d    = accept ? bus.we    : we_q;
    err_d   = accept ? bad       : err_q;
    buf_d   = (state_q == RD) ? bus.mem_dout : buf_q;
    fmt     = size_q == 2'b00 ? (uns_q ? {24'b0, bus.mem_dout[7:0]} : {{24{bus.mem_dout[7]}}, bus.mem_dout[7:0]}) :
              size_q == 2'b01 ? (uns_q ? {16'b0, bus.mem_dout[15:0]} : {{16{bus.mem_dout[15]}}, bus.mem_dout[15:0]}) :
              bus.mem_dout;
    rdata_d = (state_q == RD && !we_q) ? fmt : rdata_q;
    merge   = size_q == 2'b10 ? wdata_q :
              size_q == 2'b01 ? {buf_q[31:16], wdata_q[15:0]} : {buf_q[31:8], wdata_q[7:0]};
  end
  always_comb begin
    bus.busy    = (state_q != IDLE);
    bus.done    = (state_q == DONE);
    bus.err     = (state_q == DONE) && err_q;
    bus.mem_rd  = (state_q == RD);
    bus.mem_wr  = (state_q == WR);
    bus.mem_adr = addr_q;
    bus.mem_din = (state_q == WR) ? merge : 32'b0;
    bus.rdata   = rdata_q;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random load/store transactions against a byte-array reference memory.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0]  dmem  [0:4095];
  logic [7:0]  ref_m [0:4095];
  logic [31:0] exp_rdata = 32'h0;
  mem_access_ctrl_if #(.ADDR_W(32)) bus ();
  mem_access_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_dout = {dmem[12'(bus.mem_adr + 3)], dmem[12'(bus.mem_adr + 2)],
                         dmem[12'(bus.mem_adr + 1)], dmem[12'(bus.mem_adr)]};
  always @(posedge clk)
    if (bus.mem_wr)
      for (int i = 0; i < 4; i++) dmem[12'(bus.mem_adr + i)] <= bus.mem_din[8*i +: 8];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) chk("rd_wr_excl", {31'b0, bus.mem_rd & bus.mem_wr}, 32'h0);
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_m[12'(a + 3)], ref_m[12'(a + 2)], ref_m[12'(a + 1)], ref_m[12'(a)]};
  endfunction
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
    logic [31:0] r, b, h;
    r = ref_word(a);
    b = r % 256;
    h = r % 65536;
    if (sz == 2'd0) return u ? b : (b >= 128 ? b + 32'hFFFF_FF00 : b);
    if (sz == 2'd1) return u ? h : (h >= 32768 ? h + 32'hFFFF_0000 : h);
    return r;
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef ALIGN_CHECK_EN
    return (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction
  task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd);
    int lat, nrd, nwr, exp_lat, nbytes;
    logic [31:0] din_seen;
    logic bad;
    bad = (sz == 2'd3) || misaligned(sz, a);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_lat = bad ? 1 : (w && sz != 2'd2) ? 3 : 2;
    nrd = 0;
    nwr = 0;
    din_seen = 32'h0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    bus.req = 1'b0;
    lat = 1;
    while (!bus.done && lat < 10) begin
      nrd += int'(bus.mem_rd);
      if (bus.mem_wr) begin
        nwr++;
        din_seen = bus.mem_din;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("err", {31'b0, bus.err}, {31'b0, bad});
    chk("rd_cycles", nrd, (bad || (w && sz == 2'd2)) ? 0 : 1);
    chk("wr_cycles", nwr, (!bad && w) ? 1 : 0);
    if (!bad && w) begin
      for (int i = 0; i < nbytes; i++) ref_m[12'(a + i)] = wd[8*i +: 8];
      chk("mem_din", din_seen, ref_word(a));
    end
    if (!bad && !w) exp_rdata = ref_load(sz, u, a);
    chk("rdata", bus.rdata, exp_rdata);
    @(posedge clk); #1;
    chk("done_pulse", {30'b0, bus.done, bus.busy}, 32'h0);
  endtask
  initial begin
    logic [31:0] v;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.uns = 1'b0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 4096; i++) begin
      v = $urandom;
      dmem[i] = v[7:0];
      ref_m[i] = v[7:0];
    end
    for (int i = 0; i < 4; i++) begin
      v = 32'h80FF_1234;
      dmem[1000 + i] = v[8*i +: 8];
      ref_m[1000 + i] = v[8*i +: 8];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {27'b0, bus.busy, bus.done, bus.err, bus.mem_rd, bus.mem_wr}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_adr", bus.mem_adr, 32'h0);
    chk("rst_din", bus.mem_din, 32'h0);
    @(negedge clk) rst = 1'b0;
    xact(1'b0, 2'd0, 1'b0, 32'd1001, 32'h0);
    chk("t1_byte", bus.rdata, 32'h0000_0012);
    xact(1'b0, 2'd0, 1'b0, 32'd1003, 32'h0);
    chk("t1_sext", bus.rdata, 32'hFFFF_FF80);
    xact(1'b0, 2'd1, 1'b1, 32'd1002, 32'h0);
    chk("t2_zext", bus.rdata, 32'h0000_80FF);
    xact(1'b0, 2'd1, 1'b0, 32'd1002, 32'h0);
    chk("t2_sext", bus.rdata, 32'hFFFF_80FF);
    xact(1'b1, 2'd0, 1'b0, 32'd1000, 32'hAAAA_AA5A);
    xact(1'b0, 2'd2, 1'b0, 32'd1000, 32'h0);
    chk("t3_rmw", bus.rdata, 32'h80FF_125A);
    xact(1'b1, 2'd2, 1'b0, 32'd2000, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = 32'd2000; bus.wdata = 32'h0;
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk("t4_in_wr", {31'b0, bus.mem_wr}, 32'h1);
    rst = 1'b1;
    #1;
    chk("t4_abort_flags", {27'b0, bus.busy, bus.done, bus.err, bus.mem_rd, bus.mem_wr}, 32'h0);
    chk("t4_abort_rdata", bus.rdata, 32'h0);
    chk("t4_abort_adr", bus.mem_adr, 32'h0);
    chk("t4_abort_din", bus.mem_din, 32'h0);
    exp_rdata = 32'h0;
    @(negedge clk) rst = 1'b0;
    xact(1'b0, 2'd2, 1'b0, 32'd2000, 32'h0);
    chk("t4_reload", bus.rdata, 32'hDEAD_BEEF);
    xact(1'b0, 2'd3, 1'b0, 32'd1000, 32'h0);
    xact(1'b1, 2'd3, 1'b0, 32'd1000, 32'h1234_5678);
    xact(1'b0, 2'd2, 1'b0, 32'd1001, 32'h0);
`ifdef ALIGN_CHECK_EN
    chk("t5_align_hold", bus.rdata, 32'hDEAD_BEEF);
`else
    chk("t5_unaligned", bus.rdata, ref_word(32'd1001));
`endif
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.uns = 1'b0; bus.addr = 32'd2000;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      chk("b2b_busy", {31'b0, bus.busy}, {31'b0, k % 3 != 2});
      chk("b2b_done", {31'b0, bus.done}, {31'b0, k % 3 == 1});
      chk("b2b_rd", {31'b0, bus.mem_rd}, {31'b0, k % 3 == 0});
    end
    @(negedge clk) bus.req = 1'b0;
    exp_rdata = ref_word(32'd2000);
    chk("b2b_rdata", bus.rdata, exp_rdata);
    for (int n = 0; n < 200; n++) begin
      v = $urandom;
      xact(v[0], v[2:1], v[3], $urandom_range(0, 4095), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
